obj_row_walker: RTL and testbench

Sequential successor to the per-pixel object flip logic. For one sprite row it walks screen columns left to right and emits the texel coordinates (x per lane, y per row) to fetch, with horizontal/vertical flip applied. It is parametrised in coordinate width and pixels per beat, and drives a valid/ready stream into the object tile-address stage. It sits between the OAM attribute evaluator (which issues `start`) and the VRAM fetch pipeline.

---
 rtl/obj_row_walker_if.sv | 26 ++
 rtl/obj_row_walker.sv | 198 +++++++++++++++++++
 tb/tb_obj_row_walker.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obj_row_walker_if.sv
// Output beat stream of obj_row_walker toward the object tile-address stage.
// Latency: none (signal bundle only).
// Backpressure: a beat transfers when out_valid and out_ready are both high.
// Signals: out_valid/out_ready handshake; out_x (LANES texel x, lane 0 in the low bits),
//          out_y (texel y), out_col (screen column of lane 0), out_last (final beat of the row).
interface obj_row_walker_if #(
  parameter int COORD_W = 7,
  parameter int LANES   = 2
);
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*COORD_W-1:0] out_x;
  logic [COORD_W-1:0]       out_y;
  logic [COORD_W-1:0]       out_col;
  logic                     out_last;

  modport master (
    output out_valid, out_x, out_y, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/obj_row_walker.sv
// Walks one sprite row left to right, emitting flipped texel coordinates LANES pixels per beat.
// Latency: start at cycle N gives the first beat at N+1, one beat per cycle, done the cycle after the last handshake.
// Backpressure: a beat is held stable with out_valid high until out_ready; start is ignored while busy.
// Ports: clock, reset (synchronous, active-high); start/row/hsize/vsize/hflip/vflip row request;
//        busy (RUN or DONE), done (one-cycle pulse on finish or rejection); stream = beat output (master).
// Optional build macro OBJ_MOSAIC_EN adds mosaic_en/mosaic_h horizontal mosaic quantisation.
module obj_row_walker #(
  parameter int COORD_W = 7,
  parameter int SIZE_W  = COORD_W + 1,
  parameter int LANES   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] row,
  input  logic [SIZE_W-1:0]  hsize,
  input  logic [SIZE_W-1:0]  vsize,
  input  logic               hflip,
  input  logic               vflip,
`ifdef OBJ_MOSAIC_EN
  input  logic               mosaic_en,
  input  logic [3:0]         mosaic_h,
`endif
  output logic               busy,
  output logic               done,
  obj_row_walker_if.master   stream
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [SIZE_W-1:0]        hsize_q;
  logic                     hflip_q;

  logic                     row_ok;
  logic                     handshake;
  logic                     load;
  logic [SIZE_W-1:0]        src_col;
  logic [SIZE_W-1:0]        src_hsize;
  logic                     src_hflip;
  logic [SIZE_W-1:0]        s;
  logic [SIZE_W-1:0]        base;
  logic [LANES*COORD_W-1:0] ld_x;
  logic [COORD_W-1:0]       ld_y;
  logic                     ld_last;

`ifdef OBJ_MOSAIC_EN
  // Mosaic hold state for the column after the current beat: the quantised
  // base in force and how far into the current mosaic block that column is.
  logic                     men_q;
  logic [3:0]               mh_q;
  logic [SIZE_W-1:0]        mbase_q;
  logic [3:0]               mcnt_q;
  logic                     src_men;
  logic [3:0]               src_mh;
  logic [SIZE_W-1:0]        chain_base;
  logic [3:0]               chain_cnt;
`endif

  assign handshake = stream.out_valid && stream.out_ready;

  // Request validity: non-empty sprite, row inside it, width a whole number
  // of beats and no wider than the coordinate range.
  assign row_ok = (hsize != '0) && (vsize != '0)
               && (SIZE_W'(row) < vsize)
               && ((hsize & SIZE_W'(LANES - 1)) == '0)
               && (hsize <= (SIZE_W'(1) << COORD_W));

  assign load = ((state == IDLE) && start && row_ok)
             || ((state == RUN) && handshake && !stream.out_last);

  // Next beat: in IDLE it is the first beat of the requested row built from
  // the live inputs; in RUN it is the beat after the current one, built from
  // the values captured at start.
  always_comb begin
    if (state == IDLE) begin
      src_col   = '0;
      src_hsize = hsize;
      src_hflip = hflip;
    end else begin
      src_col   = SIZE_W'(stream.out_col) + SIZE_W'(LANES);
      src_hsize = hsize_q;
      src_hflip = hflip_q;
    end
`ifdef OBJ_MOSAIC_EN
    if (state == IDLE) begin
      src_men    = mosaic_en;
      src_mh     = mosaic_h;
      chain_base = '0;
      chain_cnt  = '0;
    end else begin
      src_men    = men_q;
      src_mh     = mh_q;
      chain_base = mbase_q;
      chain_cnt  = mcnt_q;
    end
`endif
    s    = '0;
    base = '0;
    ld_x = '0;
    for (int i = 0; i < LANES; i++) begin
      s = src_col + SIZE_W'(i);
`ifdef OBJ_MOSAIC_EN
      base = src_men ? chain_base : s;
      // Step the hold counter to column s+1: a new block starts once the
      // current one has covered mosaic_h+1 columns.
      if (chain_cnt == src_mh) begin
        chain_base = s + SIZE_W'(1);
        chain_cnt  = '0;
      end else begin
        chain_cnt  = chain_cnt + 4'd1;
      end
`else
      base = s;
`endif
      ld_x[i*COORD_W +: COORD_W] = COORD_W'(src_hflip ? (src_hsize - SIZE_W'(1) - base) : base);
    end
    ld_last = ((src_col + SIZE_W'(LANES)) == src_hsize);
    ld_y    = COORD_W'(vflip ? (vsize - SIZE_W'(1) - SIZE_W'(row)) : SIZE_W'(row));
  end

  // Control FSM: state plus the registered busy/done/out_valid flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      stream.out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (row_ok) begin
              state            <= RUN;
              stream.out_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (handshake && stream.out_last) begin
            state            <= DONE;
            stream.out_valid <= 1'b0;
            done             <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Beat registers: only change on a load, so a stalled beat holds steady.
  always_ff @(posedge clock) begin
    if (reset) begin
      stream.out_x    <= '0;
      stream.out_y    <= '0;
      stream.out_col  <= '0;
      stream.out_last <= 1'b0;
      hsize_q         <= '0;
      hflip_q         <= 1'b0;
`ifdef OBJ_MOSAIC_EN
      men_q           <= 1'b0;
      mh_q            <= '0;
      mbase_q         <= '0;
      mcnt_q          <= '0;
`endif
    end else if (load) begin
      stream.out_x    <= ld_x;
      stream.out_col  <= src_col[COORD_W-1:0];
      stream.out_last <= ld_last;
`ifdef OBJ_MOSAIC_EN
      mbase_q         <= chain_base;
      mcnt_q          <= chain_cnt;
`endif
      if (state == IDLE) begin
        stream.out_y <= ld_y;
        hsize_q      <= hsize;
        hflip_q      <= hflip;
`ifdef OBJ_MOSAIC_EN
        men_q        <= mosaic_en;
        mh_q         <= mosaic_h;
`endif
      end
    end
  end

endmodule

// File: tb/tb_obj_row_walker.sv
// Directed bench for obj_row_walker: three instances (LANES 2, 4 and 1) sharing the row request inputs.
// Inputs are driven and outputs sampled on the falling clock edge.
// Mosaic vectors run only when OBJ_MOSAIC_EN is defined.
module tb_obj_row_walker;
  localparam int CW = 7;

  logic          clock  = 1'b0;
  logic          reset  = 1'b1;
  logic          start0 = 1'b0;
  logic          start1 = 1'b0;
  logic          start2 = 1'b0;
  logic [CW-1:0] row    = '0;
  logic [CW:0]   hsize  = '0;
  logic [CW:0]   vsize  = '0;
  logic          hflip  = 1'b0;
  logic          vflip  = 1'b0;
  logic          busy0, done0, busy1, done1, busy2, done2;
`ifdef OBJ_MOSAIC_EN
  logic          mosaic_en = 1'b0;
  logic [3:0]    mosaic_h  = '0;
`endif

  int total = 0;
  int bad   = 0;

  obj_row_walker_if #(.COORD_W(CW), .LANES(2)) if0 ();
  obj_row_walker_if #(.COORD_W(CW), .LANES(4)) if1 ();
  obj_row_walker_if #(.COORD_W(CW), .LANES(1)) if2 ();

  obj_row_walker #(.COORD_W(CW), .LANES(2)) u0 (
    .clock(clock), .reset(reset), .start(start0), .row(row), .hsize(hsize), .vsize(vsize),
    .hflip(hflip), .vflip(vflip),
`ifdef OBJ_MOSAIC_EN
    .mosaic_en(mosaic_en), .mosaic_h(mosaic_h),
`endif
    .busy(busy0), .done(done0), .stream(if0)
  );

  obj_row_walker #(.COORD_W(CW), .LANES(4)) u1 (
    .clock(clock), .reset(reset), .start(start1), .row(row), .hsize(hsize), .vsize(vsize),
    .hflip(hflip), .vflip(vflip),
`ifdef OBJ_MOSAIC_EN
    .mosaic_en(mosaic_en), .mosaic_h(mosaic_h),
`endif
    .busy(busy1), .done(done1), .stream(if1)
  );

  obj_row_walker #(.COORD_W(CW), .LANES(1)) u2 (
    .clock(clock), .reset(reset), .start(start2), .row(row), .hsize(hsize), .vsize(vsize),
    .hflip(hflip), .vflip(vflip),
`ifdef OBJ_MOSAIC_EN
    .mosaic_en(mosaic_en), .mosaic_h(mosaic_h),
`endif
    .busy(busy2), .done(done2), .stream(if2)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Walks a 4-beat row on u0. tab holds the expected texel x per screen
  // column, column 0 in the low 7 bits. With stall set, out_ready follows
  // 1,0,0,1,... and hsize/hflip are disturbed mid-row.
  task automatic walk0(input string tag, input logic [55:0] tab, input logic [6:0] ey, input bit stall);
    int beat;
    int cyc;
    logic rdy;
    logic [CW:0] hs_save;
    logic hf_save;
    hs_save = hsize;
    hf_save = hflip;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 40) begin
      rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if0.out_ready = rdy;
      chk({tag, "_vld"},  32'(if0.out_valid), 32'd1);
      chk({tag, "_x"},    32'(if0.out_x), 32'(tab[beat*14 +: 14]));
      chk({tag, "_y"},    32'(if0.out_y), 32'(ey));
      chk({tag, "_col"},  32'(if0.out_col), 32'(beat * 2));
      chk({tag, "_last"}, 32'(if0.out_last), 32'(beat == 3));
      if (stall && cyc == 0) begin
        hsize = 8'd2;
        hflip = ~hf_save;
      end
      if (rdy) beat++;
      cyc++;
      @(negedge clock);
    end
    if0.out_ready = 1'b1;
    hsize = hs_save;
    hflip = hf_save;
    chk({tag, "_beats"}, 32'(beat), 32'd4);
    chk({tag, "_done"},  32'(done0), 32'd1);
    chk({tag, "_vld_end"}, 32'(if0.out_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_done_off"}, 32'(done0), 32'd0);
    chk({tag, "_idle"}, 32'(busy0), 32'd0);
  endtask

  // Walks an 8-pixel row on u2 (one pixel per beat), ready held high.
  task automatic walk2(input string tag, input logic [55:0] tab);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk({tag, "_vld"},  32'(if2.out_valid), 32'd1);
      chk({tag, "_x"},    32'(if2.out_x), 32'(tab[b*7 +: 7]));
      chk({tag, "_last"}, 32'(if2.out_last), 32'(b == 7));
      @(negedge clock);
    end
    chk({tag, "_done"}, 32'(done2), 32'd1);
    @(negedge clock);
  endtask

  initial begin
    int beats;
    int n;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    if2.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_vld",  32'(if0.out_valid), 32'd0);
    chk("rst_last", 32'(if0.out_last), 32'd0);
    chk("rst_x",    32'(if0.out_x), 32'd0);
    chk("rst_y",    32'(if0.out_y), 32'd0);
    chk("rst_col",  32'(if0.out_col), 32'd0);

    // vflip row 3 of 8 -> y 4
    hsize = 8'd8; vsize = 8'd8; row = 7'd3; vflip = 1'b1; hflip = 1'b0;
    walk0("plain", {7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0}, 7'd4, 1'b0);
    hflip = 1'b1;
    walk0("hflip", {7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7}, 7'd4, 1'b0);
    hflip = 1'b0;
    walk0("stall", {7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0}, 7'd4, 1'b1);

    // Rejected row, then a start during the done pulse must be ignored.
    row = 7'd8;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    chk("rej_done", 32'(done0), 32'd1);
    chk("rej_vld",  32'(if0.out_valid), 32'd0);
    chk("rej_busy", 32'(busy0), 32'd1);
    row = 7'd3;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    chk("ign_vld",  32'(if0.out_valid), 32'd0);
    chk("ign_busy", 32'(busy0), 32'd0);
    chk("ign_done", 32'(done0), 32'd0);

    // LANES=4: hsize 6 rejected, hsize 8 flipped gives two beats.
    if1.out_ready = 1'b1;
    hsize = 8'd6; vflip = 1'b0;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk("l4rej_done", 32'(done1), 32'd1);
    chk("l4rej_vld",  32'(if1.out_valid), 32'd0);
    @(negedge clock);
    chk("l4rej_vld2", 32'(if1.out_valid), 32'd0);
    hsize = 8'd8; hflip = 1'b1;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk("l4_vld0",  32'(if1.out_valid), 32'd1);
    chk("l4_x0",    32'(if1.out_x), 32'({7'd4, 7'd5, 7'd6, 7'd7}));
    chk("l4_last0", 32'(if1.out_last), 32'd0);
    @(negedge clock);
    chk("l4_x1",    32'(if1.out_x), 32'({7'd0, 7'd1, 7'd2, 7'd3}));
    chk("l4_col1",  32'(if1.out_col), 32'd4);
    chk("l4_last1", 32'(if1.out_last), 32'd1);
    @(negedge clock);
    chk("l4_done",  32'(done1), 32'd1);
    chk("l4_vld_end", 32'(if1.out_valid), 32'd0);
    @(negedge clock);

    // Reset after beat 2 of an 8-beat row, then a fresh row.
    hsize = 8'd16; hflip = 1'b0; row = 7'd3;
    if0.out_ready = 1'b1;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_col", 32'(if0.out_col), 32'd4);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_busy", 32'(busy0), 32'd0);
    chk("mid_vld",  32'(if0.out_valid), 32'd0);
    chk("mid_x",    32'(if0.out_x), 32'd0);
    chk("mid_y",    32'(if0.out_y), 32'd0);
    chk("mid_col0", 32'(if0.out_col), 32'd0);
    chk("mid_last", 32'(if0.out_last), 32'd0);
    chk("mid_done", 32'(done0), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_nodone", 32'(done0), 32'd0);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    chk("fresh_vld", 32'(if0.out_valid), 32'd1);
    chk("fresh_col", 32'(if0.out_col), 32'd0);
    chk("fresh_x",   32'(if0.out_x), 32'({7'd1, 7'd0}));
    chk("fresh_y",   32'(if0.out_y), 32'd3);
    n = 0;
    while (!done0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("fresh_done", 32'(done0), 32'd1);
    @(negedge clock);

    // Full-width 128-pixel flipped row on LANES=1.
    if2.out_ready = 1'b1;
    hsize = 8'd128; vsize = 8'd1; row = 7'd0; hflip = 1'b1;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    chk("w128_first", 32'(if2.out_x), 32'd127);
    chk("w128_y",     32'(if2.out_y), 32'd0);
    beats = 0;
    n = 0;
    while (!done2 && n < 200) begin
      if (if2.out_valid) begin
        beats++;
        if (if2.out_last) begin
          chk("w128_lastx",   32'(if2.out_x), 32'd0);
          chk("w128_lastcol", 32'(if2.out_col), 32'd127);
        end
      end
      n++;
      @(negedge clock);
    end
    chk("w128_beats", 32'(beats), 32'd128);
    chk("w128_done",  32'(done2), 32'd1);
    @(negedge clock);

    // One pixel wider than the coordinate range is rejected.
    hsize = 8'd129;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    chk("w129_done", 32'(done2), 32'd1);
    chk("w129_vld",  32'(if2.out_valid), 32'd0);
    @(negedge clock);

    hsize = 8'd8; vsize = 8'd8; row = 7'd3; hflip = 1'b1;
    walk2("l1flip", {7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7});

`ifdef OBJ_MOSAIC_EN
    mosaic_en = 1'b1; mosaic_h = 4'd2; hflip = 1'b0;
    walk2("mos", {7'd6, 7'd6, 7'd3, 7'd3, 7'd3, 7'd0, 7'd0, 7'd0});
    hflip = 1'b1;
    walk2("mosflip", {7'd1, 7'd1, 7'd4, 7'd4, 7'd4, 7'd7, 7'd7, 7'd7});
    mosaic_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
